// File: rtl/bks_if.sv
// bks_if: operand/result handshake bundle for the Brent-Kung subtractor pipeline
interface bks_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf, zero
  );
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf, zero
  );
endinterface

// File: rtl/bks_pipe.sv
// bks_pipe: two-stage Brent-Kung subtractor d = a - b - bin computed as a + ~b + ~bin
module bks_pipe #(
  parameter int WIDTH = 64
) (
  input logic  clk,
  input logic  rst_n,
  bks_if.slave io
);
  localparam int L = $clog2(WIDTH);
  logic                  s1_valid;
  logic                  s1_en;
  logic                  s2_en;
  logic [WIDTH-1:0]      bi;
  logic [L:0][WIDTH-1:0] ug;
  logic [L:0][WIDTH-1:0] up;
  logic [WIDTH-1:0]      r_g;
  logic [WIDTH-1:0]      r_pt;
  logic [WIDTH-1:0]      r_p;
  logic                  r_ci;
  logic                  r_am;
  logic                  r_bm;
  logic [L-1:0][WIDTH-1:0] dg;
  logic [L-1:0][WIDTH-1:0] dp;
  logic [WIDTH:0]        c;
  logic [WIDTH-1:0]      dn;
  assign s2_en       = ~io.out_valid | io.out_ready;
  assign s1_en       = ~s1_valid | s2_en;
  assign io.in_ready = s1_en;
  assign bi          = ~io.b;
  assign ug[0]       = io.a & bi;
  assign up[0]       = io.a ^ bi;
  for (genvar l = 0; l < L; l++) begin : g_up
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if ((i + 1) % (2 ** (l + 1)) == 0) begin : g_node
        assign ug[l+1][i] = ug[l][i] | (up[l][i] & ug[l][i-2**l]);
        assign up[l+1][i] = up[l][i] & up[l][i-2**l];
      end else begin : g_pass
        assign ug[l+1][i] = ug[l][i];
        assign up[l+1][i] = up[l][i];
      end
    end
  end
  assign dg[0] = r_g;
  assign dp[0] = r_pt;
  for (genvar k = 0; k < L - 1; k++) begin : g_dn
    localparam int S = 2 ** (L - 2 - k);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i + 1) % (2 * S) == S) && (i >= 2 * S)) begin : g_node
        assign dg[k+1][i] = dg[k][i] | (dp[k][i] & dg[k][i-S]);
        assign dp[k+1][i] = dp[k][i] & dp[k][i-S];
      end else begin : g_pass
        assign dg[k+1][i] = dg[k][i];
        assign dp[k+1][i] = dp[k][i];
      end
    end
  end
  assign c  = {dg[L-1] | (dp[L-1] & {WIDTH{r_ci}}), r_ci};
  assign dn = r_p ^ c[WIDTH-1:0];
  // stage 1: capture up-sweep tree, raw propagate and the sign bits needed for overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      r_g      <= '0;
      r_pt     <= '0;
      r_p      <= '0;
      r_ci     <= 1'b0;
      r_am     <= 1'b0;
      r_bm     <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= io.in_valid;
      r_g      <= ug[L];
      r_pt     <= up[L];
      r_p      <= up[0];
      r_ci     <= ~io.bin;
      r_am     <= io.a[WIDTH-1];
      r_bm     <= bi[WIDTH-1];
    end
  end
  // stage 2: register the finished difference and flags; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.d         <= '0;
      io.bout      <= 1'b0;
      io.ovf       <= 1'b0;
      io.zero      <= 1'b0;
    end else if (s2_en) begin
      io.out_valid <= s1_valid;
      io.d         <= dn;
      io.bout      <= ~c[WIDTH];
      io.ovf       <= (r_am == r_bm) && (dn[WIDTH-1] != r_am);
      io.zero      <= ~|dn;
    end
  end
endmodule

// File: tb/tb_bks_pipe.sv
// tb_bks_pipe: randomized scoreboard bench for the pipelined Brent-Kung subtractor
module tb_bks_pipe;
  typedef struct packed {
    logic [63:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bks_if #(.WIDTH(64)) io ();
  bks_pipe #(.WIDTH(64)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  res_t q[$];
  int pass_n = 0;
  int total_n = 0;
  int n_out = 0;
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic bin);
    res_t r;
    logic [64:0] u;
    logic [65:0] s;
    u = {1'b0, a} - {1'b0, b} - 65'(bin);
    s = {{2{a[63]}}, a} - {{2{b[63]}}, b} - 66'(bin);
    r.d    = u[63:0];
    r.bout = u[64];
    r.ovf  = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
    r.zero = (u[63:0] == 64'd0);
    return r;
  endfunction
  task automatic chk(input string n, input logic [66:0] got, input logic [66:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h, required %0h", n, got, exp);
  endtask
  always @(negedge clk) begin
    #1;
    if (rst_n && io.in_valid && io.in_ready) q.push_back(model(io.a, io.b, io.bin));
  end
  always @(negedge clk) begin : monitor
    res_t e;
    #1;
    if (rst_n && io.out_valid && io.out_ready) begin
      if (q.size() == 0) begin
        total_n++;
        $display("FAIL unexpected: result d=%0h emerged, required no result", io.d);
      end else begin
        e = q.pop_front();
        n_out++;
        chk("result", {io.d, io.bout, io.ovf, io.zero}, e);
      end
    end
  end
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic bin);
    int t = 0;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.a = a;
    io.b = b;
    io.bin = bin;
    #1;
    while (!io.in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t == 50) begin
      total_n++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
  endtask
  task automatic drain();
    int t = 0;
    @(negedge clk);
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    #2;
    chk("drain_empty", 67'(q.size()), 67'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [63:0] va[7];
    logic [63:0] vb[7];
    logic        vc[7];
    logic [66:0] snap;
    int          n0;
    va = '{64'd0, 64'h8000000000000000, 64'hec4160427d42eac3, 64'h456f1ede303319f6,
           64'h123456789abcdef0, 64'h123456789abcdef0, 64'h7fffffffffffffff};
    vb = '{64'd1, 64'd1, 64'h3b1c452da1aefadc, 64'h85036b62ba333a12,
           64'h123456789abcdef0, 64'h123456789abcdef0, 64'hffffffffffffffff};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.bin = 1'b0;
    io.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 67'(io.out_valid), 67'd0);
    chk("rst_in_ready", 67'(io.in_ready), 67'd1);
    chk("rst_outputs", {io.d, io.bout, io.ovf, io.zero}, 67'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(64'd5, 64'd3, 1'b0);
    @(negedge clk);
    io.in_valid = 1'b0;
    #1 chk("latency_n1", 67'(io.out_valid), 67'd0);
    @(negedge clk);
    #1 chk("latency_n2", 67'(io.out_valid), 67'd1);
    for (int i = 0; i < 7; i++) send(va[i], vb[i], vc[i]);
    drain();
    n0 = n_out;
    @(negedge clk);
    io.out_ready = 1'b0;
    io.in_valid = 1'b1;
    io.a = 64'd100; io.b = 64'd1; io.bin = 1'b0;
    #1 chk("bp_ready_a", 67'(io.in_ready), 67'd1);
    @(negedge clk);
    io.a = 64'd0; io.b = 64'd7; io.bin = 1'b1;
    #1 chk("bp_ready_b", 67'(io.in_ready), 67'd1);
    @(negedge clk);
    io.a = 64'h55; io.b = 64'h55; io.bin = 1'b0;
    #1 chk("bp_full", 67'(io.in_ready), 67'd0);
    chk("bp_out_valid", 67'(io.out_valid), 67'd1);
    snap = {io.d, io.bout, io.ovf, io.zero};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      io.a = {$urandom, $urandom};
      io.b = {$urandom, $urandom};
      #1 chk("bp_stall_ready", 67'(io.in_ready), 67'd0);
      chk("bp_stall_hold", {io.d, io.bout, io.ovf, io.zero}, snap);
    end
    @(negedge clk);
    io.a = 64'h8000000000000000; io.b = 64'd0; io.bin = 1'b1;
    io.out_ready = 1'b1;
    @(posedge clk);
    drain();
    chk("bp_count", 67'(n_out - n0), 67'd3);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      io.in_valid = ($urandom % 4) != 0;
      io.out_ready = ($urandom % 4) != 0;
      io.bin = $urandom % 2;
      io.a = {$urandom, $urandom};
      io.b = {$urandom, $urandom};
      case ($urandom % 8)
        0: io.b = io.a;
        1: io.a = 64'd0;
        2: io.b = 64'hffffffffffffffff;
        3: io.a = 64'h8000000000000000;
        default: ;
      endcase
    end
    drain();
    @(negedge clk);
    io.out_ready = 1'b0;
    io.in_valid = 1'b1;
    io.a = 64'd9; io.b = 64'd4; io.bin = 1'b0;
    @(negedge clk);
    io.a = 64'd1; io.b = 64'd2;
    @(negedge clk);
    io.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", 67'(io.out_valid), 67'd0);
    chk("mid_rst_in_ready", 67'(io.in_ready), 67'd1);
    @(negedge clk);
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1 chk("post_rst_no_stale", 67'(io.out_valid), 67'd0);
    n0 = n_out;
    send(64'h123456789abcdef0, 64'h0fedcba987654321, 1'b1);
    drain();
    chk("post_rst_count", 67'(n_out - n0), 67'd1);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
